functional_unit: RTL and testbench

- Execution stage directly downstream of each reservation station: one instance for the adder (ADD_OR_MUL=0), one for the multiplier (ADD_OR_MUL=1).
- Accepts one issued instruction (tag, a, b) from its reservation station and computes for a fixed number of cycles.
- Holds the result and requests the common data bus (CDB) until the bus arbiter grants it.
- When granted, drives the CDB for one cycle, which frees the reservation-station slot and wakes up dependent entries.

---
 rtl/functional_unit.sv | 152 +++++++++++++++
 tb/tb_functional_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/functional_unit.sv
// functional_unit
//
// Execution stage that sits behind one reservation station. It accepts one
// issued instruction (tag, a, b), computes for LATENCY cycles, then holds the
// result and requests the common data bus until the arbiter grants it. The
// granted result is broadcast for exactly one cycle.
//
// Parameters:
//   ADD_OR_MUL : 0 = 32-bit add, 1 = 32-bit multiply (low word of product)
//   LATENCY    : compute cycles from accept to result-ready, 1..15
//
// Ports:
//   clk                   in   clock, all state changes on the rising edge
//   reset                 in   synchronous active-high reset
//   new_instruction       in   issue strobe from the reservation station
//   instruction_tag[2:0]  in   {ADD_OR_MUL, RS slot index}
//   a[31:0], b[31:0]      in   operands
//   functional_unit_ready out  unit can accept an issue this cycle
//   cdb_request           out  result held, waiting for the bus
//   cdb_grant             in   arbiter grant, only honoured while requesting
//   bus_valid_output      out  one-cycle broadcast strobe
//   broadcasted_tag[2:0]  out  tag of the broadcast result
//   broadcasted_value[31:0] out result value of the broadcast

module functional_unit #(
    parameter bit ADD_OR_MUL = 1'b0,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_instruction,
    input  logic [2:0]  instruction_tag,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        functional_unit_ready,
    output logic        cdb_request,
    input  logic        cdb_grant,
    output logic        bus_valid_output,
    output logic [2:0]  broadcasted_tag,
    output logic [31:0] broadcasted_value
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_t      state, state_next;
    logic [3:0]  countdown, countdown_next;
    logic [2:0]  tag_reg, tag_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [31:0] result_reg, result_next;
    logic        bus_valid_next;
    logic [2:0]  broadcasted_tag_next;
    logic [31:0] broadcasted_value_next;

    // The multiply keeps only the low 32 bits, which is also the correct low
    // word for two's-complement operands, so no signed variant is needed.
    function automatic logic [31:0] compute(input logic [31:0] x, input logic [31:0] y);
        if (ADD_OR_MUL)
            return x * y;
        else
            return x + y;
    endfunction

    // Both outputs are decoded purely from state so nothing combinational
    // leaks from the inputs to the outputs.
    assign functional_unit_ready = (state == IDLE);
    assign cdb_request           = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            countdown         <= 4'd0;
            tag_reg           <= 3'd0;
            a_reg             <= 32'd0;
            b_reg             <= 32'd0;
            result_reg        <= 32'd0;
            bus_valid_output  <= 1'b0;
            broadcasted_tag   <= 3'd0;
            broadcasted_value <= 32'd0;
        end else begin
            state             <= state_next;
            countdown         <= countdown_next;
            tag_reg           <= tag_next;
            a_reg             <= a_next;
            b_reg             <= b_next;
            result_reg        <= result_next;
            bus_valid_output  <= bus_valid_next;
            broadcasted_tag   <= broadcasted_tag_next;
            broadcasted_value <= broadcasted_value_next;
        end
    end

    always_comb begin
        state_next             = state;
        countdown_next         = countdown;
        tag_next               = tag_reg;
        a_next                 = a_reg;
        b_next                 = b_reg;
        result_next            = result_reg;
        bus_valid_next         = 1'b0;
        broadcasted_tag_next   = broadcasted_tag;
        broadcasted_value_next = broadcasted_value;

        case (state)
            IDLE: begin
                if (new_instruction) begin
                    tag_next = instruction_tag;
                    a_next   = a;
                    b_next   = b;
                    // A single-cycle unit skips BUSY entirely, so the result
                    // has to be formed straight from the incoming operands.
                    if (LATENCY == 1) begin
                        result_next = compute(a, b);
                        state_next  = DONE;
                    end else begin
                        countdown_next = COUNT_INIT;
                        state_next     = BUSY;
                    end
                end
            end

            BUSY: begin
                if (countdown == 4'd0) begin
                    result_next = compute(a_reg, b_reg);
                    state_next  = DONE;
                end else begin
                    countdown_next = countdown - 4'd1;
                end
            end

            DONE: begin
                if (cdb_grant) begin
                    state_next             = IDLE;
                    bus_valid_next         = 1'b1;
                    broadcasted_tag_next   = tag_reg;
                    broadcasted_value_next = result_reg;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_functional_unit.sv
// tb_functional_unit
//
// Drives an adder instance (LATENCY 2) and a multiplier instance (LATENCY 4)
// from shared stimulus and compares both against a transaction-level
// reference model built from accept timestamps rather than a state machine.

module tb_functional_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_instruction;
    logic        cdb_grant;
    logic [31:0] a, b;
    logic [2:0]  tag_in [2];

    logic        ready [2];
    logic        req   [2];
    logic        valid [2];
    logic [2:0]  btag  [2];
    logic [31:0] bval  [2];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    functional_unit #(.ADD_OR_MUL(1'b0), .LATENCY(2)) dut_add (
        .clk                   (clk),
        .reset                 (reset),
        .new_instruction       (new_instruction),
        .instruction_tag       (tag_in[0]),
        .a                     (a),
        .b                     (b),
        .functional_unit_ready (ready[0]),
        .cdb_request           (req[0]),
        .cdb_grant             (cdb_grant),
        .bus_valid_output      (valid[0]),
        .broadcasted_tag       (btag[0]),
        .broadcasted_value     (bval[0])
    );

    functional_unit #(.ADD_OR_MUL(1'b1), .LATENCY(4)) dut_mul (
        .clk                   (clk),
        .reset                 (reset),
        .new_instruction       (new_instruction),
        .instruction_tag       (tag_in[1]),
        .a                     (a),
        .b                     (b),
        .functional_unit_ready (ready[1]),
        .cdb_request           (req[1]),
        .cdb_grant             (cdb_grant),
        .bus_valid_output      (valid[1]),
        .broadcasted_tag       (btag[1]),
        .broadcasted_value     (bval[1])
    );

    // Reference model: an accepted instruction is remembered with the edge
    // number at which its result becomes available; the bus is requested from
    // then on until a grant moves the result onto the broadcast registers.
    localparam int LAT [2] = '{2, 4};
    int          edge_no = 0;
    bit          in_flight [2];
    int          done_at   [2];
    logic [31:0] m_res     [2];
    logic [2:0]  m_tag     [2];
    logic        m_valid   [2];
    logic [2:0]  m_btag    [2];
    logic [31:0] m_bval    [2];
    logic [37:0] expv      [2];
    bit          was_ready, was_req;

    always @(posedge clk) begin
        edge_no = edge_no + 1;
        for (int u = 0; u < 2; u++) begin
            was_ready  = !in_flight[u];
            was_req    = in_flight[u] && (edge_no - 1 >= done_at[u]);
            m_valid[u] = 1'b0;
            if (reset) begin
                in_flight[u] = 1'b0;
                m_btag[u]    = 3'd0;
                m_bval[u]    = 32'd0;
            end else if (was_ready && new_instruction) begin
                in_flight[u] = 1'b1;
                done_at[u]   = edge_no + LAT[u];
                m_tag[u]     = tag_in[u];
                m_res[u]     = (u == 0) ? a + b : a * b;
            end else if (was_req && cdb_grant) begin
                in_flight[u] = 1'b0;
                m_valid[u]   = 1'b1;
                m_btag[u]    = m_tag[u];
                m_bval[u]    = m_res[u];
            end
            expv[u] = {!in_flight[u], in_flight[u] && (edge_no >= done_at[u]),
                       m_valid[u], m_btag[u], m_bval[u]};
        end
    end

    task automatic test_reset();
        reset = 1'b1; new_instruction = 1'b0; cdb_grant = 1'b0;
        a = 32'd0; b = 32'd0; tag_in[0] = 3'b000; tag_in[1] = 3'b100;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            compared++;
            if ({ready[u], req[u], valid[u], bval[u]} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
                mismatched++;
                $display("[TB] FAIL reset_idle unit%0d got rdy/req/vld=%b%b%b val=%h, want 100 val=0",
                         u, ready[u], req[u], valid[u], bval[u]);
            end
            compared++;
            if ({ready[u], req[u], valid[u], btag[u], bval[u]} !== expv[u]) begin
                mismatched++;
                $display("[TB] FAIL reset_model unit%0d got=%h want=%h", u,
                         {ready[u], req[u], valid[u], btag[u], bval[u]}, expv[u]);
            end
        end
    endtask

    task automatic test_add_immediate();
        int pulses = 0;
        new_instruction = 1'b1; a = 32'd7; b = 32'd5;
        tag_in[0] = 3'b001; tag_in[1] = 3'b101; cdb_grant = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            new_instruction = 1'b0;
            for (int u = 0; u < 2; u++) begin
                compared++;
                if ({ready[u], req[u], valid[u], btag[u], bval[u]} !== expv[u]) begin
                    mismatched++;
                    $display("[TB] FAIL add_imm_model k=%0d unit%0d got=%h want=%h", k, u,
                             {ready[u], req[u], valid[u], btag[u], bval[u]}, expv[u]);
                end
            end
            if (valid[0] === 1'b1) pulses++;
            if (k == 2) begin
                compared++;
                if (req[0] !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL add_imm_request got=%b want=1", req[0]);
                end
            end
            if (k == 3) begin
                compared++;
                if ({valid[0], btag[0], bval[0]} !== {1'b1, 3'b001, 32'd12}) begin
                    mismatched++;
                    $display("[TB] FAIL add_imm_broadcast got vld=%b tag=%b val=%0d want 1/001/12",
                             valid[0], btag[0], bval[0]);
                end
            end
            if (k == 5) begin
                compared++;
                if ({valid[1], btag[1], bval[1]} !== {1'b1, 3'b101, 32'd35}) begin
                    mismatched++;
                    $display("[TB] FAIL mul_imm_broadcast got vld=%b tag=%b val=%0d want 1/101/35",
                             valid[1], btag[1], bval[1]);
                end
            end
        end
        compared++;
        if (pulses != 1 || ready[0] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL add_imm_single_pulse got pulses=%0d ready=%b want 1/1", pulses, ready[0]);
        end
    endtask

    task automatic test_mul_wrap();
        logic [31:0] ops_a [2];
        logic [31:0] ops_b [2];
        logic [31:0] want  [2];
        ops_a[0] = 32'h0001_0000; ops_b[0] = 32'h0001_0003; want[0] = 32'h0003_0000;
        ops_a[1] = 32'hFFFF_FFFF; ops_b[1] = 32'd2;         want[1] = 32'hFFFF_FFFE;
        cdb_grant = 1'b1;
        for (int t = 0; t < 2; t++) begin
            new_instruction = 1'b1; a = ops_a[t]; b = ops_b[t];
            tag_in[0] = {1'b0, 2'(t + 2)}; tag_in[1] = {1'b1, 2'(t + 2)};
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                new_instruction = 1'b0;
                for (int u = 0; u < 2; u++) begin
                    compared++;
                    if ({ready[u], req[u], valid[u], btag[u], bval[u]} !== expv[u]) begin
                        mismatched++;
                        $display("[TB] FAIL mul_wrap_model t=%0d k=%0d unit%0d got=%h want=%h", t, k, u,
                                 {ready[u], req[u], valid[u], btag[u], bval[u]}, expv[u]);
                    end
                end
                if (k == 5) begin
                    compared++;
                    if ({valid[1], btag[1], bval[1]} !== {1'b1, 1'b1, 2'(t + 2), want[t]}) begin
                        mismatched++;
                        $display("[TB] FAIL mul_wrap_value t=%0d got vld=%b tag=%b val=%h want 1/1%b/%h",
                                 t, valid[1], btag[1], bval[1], 2'(t + 2), want[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        int pulses [2];
        pulses[0] = 0; pulses[1] = 0;
        cdb_grant = 1'b0; new_instruction = 1'b1; a = 32'd3; b = 32'd4;
        tag_in[0] = 3'b010; tag_in[1] = 3'b110;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            new_instruction = 1'b0;
            for (int u = 0; u < 2; u++) begin
                compared++;
                if ({ready[u], req[u], valid[u], btag[u], bval[u]} !== expv[u]) begin
                    mismatched++;
                    $display("[TB] FAIL stall_model k=%0d unit%0d got=%h want=%h", k, u,
                             {ready[u], req[u], valid[u], btag[u], bval[u]}, expv[u]);
                end
            end
            if (k == 8) begin
                new_instruction = 1'b1; a = 32'd99; b = 32'd99;
            end
        end
        for (int u = 0; u < 2; u++) begin
            compared++;
            if ({ready[u], req[u], valid[u]} !== 3'b010) begin
                mismatched++;
                $display("[TB] FAIL stall_hold unit%0d got rdy/req/vld=%b%b%b want 010",
                         u, ready[u], req[u], valid[u]);
            end
        end
        cdb_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) if (valid[u] === 1'b1) pulses[u]++;
            if (valid[0] === 1'b1) begin
                compared++;
                if (bval[0] !== 32'd7 || btag[0] !== 3'b010) begin
                    mismatched++;
                    $display("[TB] FAIL stall_add_result got tag=%b val=%0d want 010/7", btag[0], bval[0]);
                end
            end
            if (valid[1] === 1'b1) begin
                compared++;
                if (bval[1] !== 32'd12 || btag[1] !== 3'b110) begin
                    mismatched++;
                    $display("[TB] FAIL stall_mul_result got tag=%b val=%0d want 110/12", btag[1], bval[1]);
                end
            end
        end
        compared++;
        if (pulses[0] != 1 || pulses[1] != 1) begin
            mismatched++;
            $display("[TB] FAIL stall_pulses got add=%0d mul=%0d want 1/1", pulses[0], pulses[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit second_issued = 1'b0;
        int issue_k = 0;
        cdb_grant = 1'b1; new_instruction = 1'b1; a = 32'd10; b = 32'd20;
        tag_in[0] = 3'b011; tag_in[1] = 3'b111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            new_instruction = 1'b0;
            for (int u = 0; u < 2; u++) begin
                compared++;
                if ({ready[u], req[u], valid[u], btag[u], bval[u]} !== expv[u]) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_model k=%0d unit%0d got=%h want=%h", k, u,
                             {ready[u], req[u], valid[u], btag[u], bval[u]}, expv[u]);
                end
            end
            if (second_issued && k == issue_k + 1) begin
                compared++;
                if (ready[0] !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_accept got ready=%b want 0", ready[0]);
                end
            end
            if (second_issued && k == issue_k + 4) begin
                compared++;
                if ({valid[0], btag[0], bval[0]} !== {1'b1, 3'b000, 32'd2}) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_result got vld=%b tag=%b val=%0d want 1/000/2",
                             valid[0], btag[0], bval[0]);
                end
            end
            if (valid[0] === 1'b1 && !second_issued) begin
                new_instruction = 1'b1; a = 32'd1; b = 32'd1;
                tag_in[0] = 3'b000; tag_in[1] = 3'b100;
                second_issued = 1'b1;
                issue_k = k;
            end
        end
        compared++;
        if (!second_issued) begin
            mismatched++;
            $display("[TB] FAIL b2b_timeout got no broadcast within 12 cycles, want one");
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int phase = 0; phase < 2; phase++) begin
            cdb_grant = (phase == 0);
            new_instruction = 1'b1; a = 32'd6; b = 32'd9;
            tag_in[0] = 3'b001; tag_in[1] = 3'b101;
            repeat (phase == 0 ? 1 : 6) begin
                @(negedge clk);
                new_instruction = 1'b0;
            end
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            cdb_grant = 1'b1;
            for (int u = 0; u < 2; u++) begin
                compared++;
                if ({ready[u], req[u], valid[u]} !== 3'b100) begin
                    mismatched++;
                    $display("[TB] FAIL reset_mid_idle phase=%0d unit%0d got rdy/req/vld=%b%b%b want 100",
                             phase, u, ready[u], req[u], valid[u]);
                end
            end
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                for (int u = 0; u < 2; u++) begin
                    if (valid[u] !== 1'b0) pulses++;
                    compared++;
                    if ({ready[u], req[u], valid[u], btag[u], bval[u]} !== expv[u]) begin
                        mismatched++;
                        $display("[TB] FAIL reset_mid_model phase=%0d k=%0d unit%0d got=%h want=%h",
                                 phase, k, u, {ready[u], req[u], valid[u], btag[u], bval[u]}, expv[u]);
                    end
                end
            end
        end
        compared++;
        if (pulses != 0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_no_broadcast got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                compared++;
                if ({ready[u], req[u], valid[u], btag[u], bval[u]} !== expv[u]) begin
                    mismatched++;
                    $display("[TB] FAIL random_model k=%0d unit%0d got=%h want=%h", k, u,
                             {ready[u], req[u], valid[u], btag[u], bval[u]}, expv[u]);
                end
            end
            reset           = ($urandom_range(0, 63) == 0);
            new_instruction = 1'($urandom_range(0, 1));
            cdb_grant       = ($urandom_range(0, 2) != 0);
            a               = $urandom;
            b               = $urandom;
            tag_in[0]       = {1'b0, 2'($urandom_range(0, 3))};
            tag_in[1]       = {1'b1, 2'($urandom_range(0, 3))};
        end
        reset = 1'b0; new_instruction = 1'b0; cdb_grant = 1'b0;
    endtask

    initial begin
        $display("[TB] functional_unit bench start");
        test_reset();
        test_add_immediate();
        test_mul_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
